// File: rtl/cursor_controller.sv
// rtl/cursor_controller.sv - button-driven tile cursor with hold-to-repeat and select handshake
// Inputs are double-flop synchronized; directions step with wrap-around, select raises one request per press.
module cursor_controller #(
  parameter int COLS         = 8,
  parameter int ROWS         = 6,
  parameter int X_W          = 3,
  parameter int Y_W          = 3,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int CNT_W        = 25
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           up,
  input  logic           right,
  input  logic           down,
  input  logic           left,
  input  logic           s,
  output logic [X_W-1:0] cur_x,
  output logic [Y_W-1:0] cur_y,
  output logic           move_pulse,
  output logic           sel_valid,
  output logic [X_W-1:0] sel_x,
  output logic [Y_W-1:0] sel_y,
  input  logic           sel_ready
);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;

  localparam logic [CNT_W-1:0] DELAY_TC = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_TC  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [X_W-1:0]   X_LAST   = X_W'(COLS - 1);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(ROWS - 1);

  // Bit order in the synchronizer: {s, left, down, right, up}
  logic [4:0]       sync1_q, sync2_q;
  logic             s_prev_q;
  state_t           state_q, state_d;
  dir_t             dir_q, dir_d, step_dir;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [X_W-1:0]   cur_x_q, cur_x_d, sel_x_q, sel_x_d;
  logic [Y_W-1:0]   cur_y_q, cur_y_d, sel_y_q, sel_y_d;
  logic             move_pulse_q, sel_valid_q, sel_valid_d;
  logic             step, held, sel_edge;
  logic [3:0]       dirs;

  assign dirs     = sync2_q[3:0];
  assign held     = dirs[dir_q];
  assign sel_edge = sync2_q[4] & ~s_prev_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    step_dir = dir_q;
    step     = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|dirs) begin
            if (dirs[0])      step_dir = DIR_UP;
            else if (dirs[1]) step_dir = DIR_RIGHT;
            else if (dirs[2]) step_dir = DIR_DOWN;
            else              step_dir = DIR_LEFT;
            dir_d   = step_dir;
            step    = 1'b1;
            cnt_d   = '0;
            state_d = DELAY;
          end
        end
        DELAY, REPEAT: begin
          if (!held) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == ((state_q == DELAY) ? DELAY_TC : RATE_TC)) begin
            step    = 1'b1;
            cnt_d   = '0;
            state_d = REPEAT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    if (step) begin
      case (step_dir)
        DIR_UP:    cur_y_d = (cur_y_q == '0)     ? Y_LAST : cur_y_q - Y_W'(1);
        DIR_RIGHT: cur_x_d = (cur_x_q == X_LAST) ? '0     : cur_x_q + X_W'(1);
        DIR_DOWN:  cur_y_d = (cur_y_q == Y_LAST) ? '0     : cur_y_q + Y_W'(1);
        default:   cur_x_d = (cur_x_q == '0)     ? X_LAST : cur_x_q - X_W'(1);
      endcase
    end
  end

  // Capture uses the pre-step position; a press while a request is pending is dropped.
  always_comb begin
    sel_valid_d = sel_valid_q;
    sel_x_d     = sel_x_q;
    sel_y_d     = sel_y_q;
    if (en && sel_edge && !sel_valid_q) begin
      sel_valid_d = 1'b1;
      sel_x_d     = cur_x_q;
      sel_y_d     = cur_y_q;
    end else if (sel_valid_q && sel_ready) begin
      sel_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      s_prev_q     <= 1'b0;
      state_q      <= IDLE;
      dir_q        <= DIR_UP;
      cnt_q        <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      move_pulse_q <= 1'b0;
      sel_valid_q  <= 1'b0;
      sel_x_q      <= '0;
      sel_y_q      <= '0;
    end else begin
      sync1_q      <= {s, left, down, right, up};
      sync2_q      <= sync1_q;
      s_prev_q     <= sync2_q[4];
      state_q      <= state_d;
      dir_q        <= dir_d;
      cnt_q        <= cnt_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      move_pulse_q <= step;
      sel_valid_q  <= sel_valid_d;
      sel_x_q      <= sel_x_d;
      sel_y_q      <= sel_y_d;
    end
  end

  assign cur_x      = cur_x_q;
  assign cur_y      = cur_y_q;
  assign move_pulse = move_pulse_q;
  assign sel_valid  = sel_valid_q;
  assign sel_x      = sel_x_q;
  assign sel_y      = sel_y_q;

endmodule

// File: tb/tb_cursor_controller.sv
// tb/tb_cursor_controller.sv - directed table plus randomized run against a cycle-level reference model
// The model tracks cycles since the first step of a hold rather than a counter/FSM.
module tb_cursor_controller;
  localparam int COLS = 8;
  localparam int ROWS = 6;
  localparam int RD   = 10;
  localparam int RR   = 4;

  localparam logic [4:0] N = 5'b00000;
  localparam logic [4:0] U = 5'b00001;
  localparam logic [4:0] R = 5'b00010;
  localparam logic [4:0] D = 5'b00100;
  localparam logic [4:0] L = 5'b01000;
  localparam logic [4:0] S = 5'b10000;

  logic       clk = 1'b0;
  logic       rst, en, sel_ready;
  logic [4:0] btn;
  logic [2:0] cur_x, cur_y, sel_x, sel_y;
  logic       move_pulse, sel_valid;

  always #5 clk = ~clk;

  cursor_controller #(
    .COLS(COLS), .ROWS(ROWS), .X_W(3), .Y_W(3),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .up(btn[0]), .right(btn[1]), .down(btn[2]), .left(btn[3]), .s(btn[4]),
    .cur_x(cur_x), .cur_y(cur_y), .move_pulse(move_pulse),
    .sel_valid(sel_valid), .sel_x(sel_x), .sel_y(sel_y), .sel_ready(sel_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [4:0] pipe[$];
  int  mdir, age, mx, my, msx, msy;
  bit  mpulse, pend, prev_s;

  task automatic model_reset();
    pipe.delete();
    mdir = -1; age = 0; mx = 0; my = 0; msx = 0; msy = 0;
    mpulse = 0; pend = 0; prev_s = 0;
  endtask

  task automatic model_edge(input logic [4:0] b, input logic e, input logic r);
    logic [4:0] eff;
    int sdir;
    bit sedge;
    pipe.push_back(b);
    if (pipe.size() > 3) void'(pipe.pop_front());
    eff  = (pipe.size() == 3) ? pipe[0] : 5'b0;
    sdir = -1;
    if (!e) begin
      mdir = -1;
    end else if (mdir < 0) begin
      for (int i = 3; i >= 0; i--) if (eff[i]) sdir = i;
      if (sdir >= 0) begin
        mdir = sdir;
        age  = 0;
      end
    end else if (!eff[mdir]) begin
      mdir = -1;
    end else begin
      age++;
      if (age == RD || (age > RD && (age - RD) % RR == 0)) sdir = mdir;
    end
    sedge  = eff[4] && !prev_s;
    prev_s = eff[4];
    if (e && sedge && !pend) begin
      pend = 1; msx = mx; msy = my;
    end else if (pend && r) begin
      pend = 0;
    end
    case (sdir)
      0: my = (my + ROWS - 1) % ROWS;
      1: mx = (mx + 1) % COLS;
      2: my = (my + 1) % ROWS;
      3: mx = (mx + COLS - 1) % COLS;
      default: ;
    endcase
    mpulse = (sdir >= 0);
  endtask

  task automatic check_model(input string name);
    vectors++;
    if (int'(cur_x) != mx || int'(cur_y) != my || move_pulse !== mpulse ||
        sel_valid !== pend || int'(sel_x) != msx || int'(sel_y) != msy) begin
      miscompares++;
      $display("FAIL %s t=%0t: dut x=%0d y=%0d mp=%0b sv=%0b sx=%0d sy=%0d, expected x=%0d y=%0d mp=%0b sv=%0b sx=%0d sy=%0d",
               name, $time, cur_x, cur_y, move_pulse, sel_valid, sel_x, sel_y,
               mx, my, mpulse, pend, msx, msy);
    end
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if (cur_x !== 3'd0 || cur_y !== 3'd0 || move_pulse !== 1'b0 ||
        sel_valid !== 1'b0 || sel_x !== 3'd0 || sel_y !== 3'd0) begin
      miscompares++;
      $display("FAIL %s: dut x=%0d y=%0d mp=%0b sv=%0b sx=%0d sy=%0d, expected all zero",
               name, cur_x, cur_y, move_pulse, sel_valid, sel_x, sel_y);
    end
  endtask

  task automatic cycle(input logic [4:0] b, input logic e, input logic r);
    btn = b; en = e; sel_ready = r;
    @(posedge clk);
    model_edge(b, e, r);
    #1;
    check_model("cycle");
  endtask

  typedef struct {
    logic [4:0] b;
    logic       e;
    logic       r;
    int         n;
    int         x, y, p;
    logic       sv;
    int         sx, sy;
  } vec_t;

  function automatic vec_t mk(logic [4:0] b, logic e, logic r, int n,
                              int x, int y, int p, logic sv, int sx, int sy);
    vec_t v;
    v.b = b; v.e = e; v.r = r; v.n = n;
    v.x = x; v.y = y; v.p = p; v.sv = sv; v.sx = sx; v.sy = sy;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [4:0] rb;
    logic re, rr;
    int pulses;

    tbl.push_back(mk(R, 1, 0, 3, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(N, 1, 0, 5, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(L, 1, 0, 3, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(N, 1, 0, 5, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(L, 1, 0, 3, 7, 0, 1, 0, 0, 0));
    tbl.push_back(mk(N, 1, 0, 5, 7, 0, 0, 0, 0, 0));
    tbl.push_back(mk(R, 1, 0, 3, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(N, 1, 0, 5, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(U, 1, 0, 3, 0, 5, 1, 0, 0, 0));
    tbl.push_back(mk(N, 1, 0, 5, 0, 5, 0, 0, 0, 0));
    tbl.push_back(mk(D, 1, 0, 3, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(N, 1, 0, 5, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(R, 1, 0, 25, 5, 0, 5, 0, 0, 0));
    tbl.push_back(mk(N, 1, 0, 5, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(L, 1, 0, 3, 4, 0, 1, 0, 0, 0));
    tbl.push_back(mk(N, 1, 0, 5, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(L, 1, 0, 3, 3, 0, 1, 0, 0, 0));
    tbl.push_back(mk(N, 1, 0, 5, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(L, 1, 0, 3, 2, 0, 1, 0, 0, 0));
    tbl.push_back(mk(N, 1, 0, 5, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(D, 1, 0, 3, 2, 1, 1, 0, 0, 0));
    tbl.push_back(mk(N, 1, 0, 5, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mk(D, 1, 0, 3, 2, 2, 1, 0, 0, 0));
    tbl.push_back(mk(N, 1, 0, 5, 2, 2, 0, 0, 0, 0));
    tbl.push_back(mk(U | L, 1, 0, 3, 2, 1, 1, 0, 0, 0));
    tbl.push_back(mk(L, 1, 0, 4, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(N, 1, 0, 5, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(R, 1, 0, 3, 2, 1, 1, 0, 0, 0));
    tbl.push_back(mk(N, 1, 0, 5, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mk(R, 1, 0, 3, 3, 1, 1, 0, 0, 0));
    tbl.push_back(mk(N, 1, 0, 5, 3, 1, 0, 0, 0, 0));
    tbl.push_back(mk(D, 1, 0, 3, 3, 2, 1, 0, 0, 0));
    tbl.push_back(mk(N, 1, 0, 5, 3, 2, 0, 0, 0, 0));
    tbl.push_back(mk(S, 1, 0, 1, 3, 2, 0, 0, 0, 0));
    tbl.push_back(mk(N, 1, 0, 3, 3, 2, 0, 1, 3, 2));
    tbl.push_back(mk(R, 1, 0, 3, 4, 2, 1, 1, 3, 2));
    tbl.push_back(mk(N, 1, 0, 5, 4, 2, 0, 1, 3, 2));
    tbl.push_back(mk(S, 1, 0, 1, 4, 2, 0, 1, 3, 2));
    tbl.push_back(mk(N, 1, 0, 4, 4, 2, 0, 1, 3, 2));
    tbl.push_back(mk(N, 1, 1, 1, 4, 2, 0, 0, 3, 2));
    tbl.push_back(mk(N, 1, 0, 2, 4, 2, 0, 0, 3, 2));
    tbl.push_back(mk(D, 0, 0, 40, 4, 2, 0, 0, 3, 2));
    tbl.push_back(mk(N, 0, 0, 3, 4, 2, 0, 0, 3, 2));
    tbl.push_back(mk(N, 1, 0, 5, 4, 2, 0, 0, 3, 2));

    rst = 1'b0; en = 1'b1; sel_ready = 1'b0; btn = N;
    model_reset();
    #12;
    check_zero("reset_state");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      pulses = 0;
      for (int c = 0; c < tbl[i].n; c++) begin
        cycle(tbl[i].b, tbl[i].e, tbl[i].r);
        if (move_pulse === 1'b1) pulses++;
      end
      vectors++;
      if (int'(cur_x) != tbl[i].x || int'(cur_y) != tbl[i].y || pulses != tbl[i].p ||
          sel_valid !== tbl[i].sv || int'(sel_x) != tbl[i].sx || int'(sel_y) != tbl[i].sy) begin
        miscompares++;
        $display("FAIL row%0d: dut x=%0d y=%0d pulses=%0d sv=%0b sx=%0d sy=%0d, expected x=%0d y=%0d pulses=%0d sv=%0b sx=%0d sy=%0d",
                 i, cur_x, cur_y, pulses, sel_valid, sel_x, sel_y,
                 tbl[i].x, tbl[i].y, tbl[i].p, tbl[i].sv, tbl[i].sx, tbl[i].sy);
      end
    end

    // Hold right into the repeat phase, then reset between edges.
    for (int c = 0; c < 20; c++) cycle(R, 1, 0);
    #2;
    rst = 1'b0;
    btn = N;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 6; c++) cycle(N, 1, 0);

    rb = N;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) rb[3:0] = 4'($urandom());
      if ($urandom_range(0, 7) == 0) rb[4] = ~rb[4];
      re = ($urandom_range(0, 19) != 0);
      rr = ($urandom_range(0, 3) == 0);
      cycle(rb, re, rr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
